// File: rtl/game_state_ctrl_pkg.sv
// Shared types and scoring constants for the pacman game-flow controller.
package game_state_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    READY       = 3'd1,
    PLAY        = 3'd2,
    DYING       = 3'd3,
    LEVEL_CLEAR = 3'd4,
    GAME_OVER   = 3'd5
  } game_state_t;

  localparam int CANDY_PTS      = 10;
  localparam int COOKIE_PTS     = 50;
  localparam int GHOST_PTS_BASE = 200;

  localparam logic [1:0] CHAIN_MAX = 2'd3;

  function automatic logic [8:0] abs_diff9(input logic [8:0] a, input logic [8:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/game_state_ctrl_ghost_collide.sv
// Per-ghost registered proximity test against pacman (box of +/-(COLL_DIST-1) px).
module game_state_ctrl_ghost_collide
  import game_state_ctrl_pkg::*;
#(
  parameter int COLL_DIST = 4
)(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [8:0] i_x_pac,
  input  logic [8:0] i_y_pac,
  input  logic [8:0] i_x_ghost,
  input  logic [8:0] i_y_ghost,
  output logic       o_hit
);

  logic [8:0] w_dx;
  logic [8:0] w_dy;

  assign w_dx = abs_diff9(i_x_pac, i_x_ghost);
  assign w_dy = abs_diff9(i_y_pac, i_y_ghost);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_hit <= 1'b0;
    else          o_hit <= (w_dx < 9'(COLL_DIST)) && (w_dy < 9'(COLL_DIST));
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow controller: state machine, lives/level, saturating score and frightened mode.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int N_GHOSTS      = 4,
  parameter int SCORE_W       = 16,
  parameter int LIVES_INIT    = 3,
  parameter int CANDY_TOTAL   = 244,
  parameter int FRIGHT_FRAMES = 360,
  parameter int READY_FRAMES  = 120,
  parameter int DEATH_FRAMES  = 90,
  parameter int CLEAR_FRAMES  = 120,
  parameter int COLL_DIST     = 4
)(
  input  logic                     vga_pix_clk,
  input  logic                     rst_n,
  input  logic                     frame_stb,
  input  logic                     start_btn,
  input  logic                     ate_candy_stb,
  input  logic                     ate_power_cookie_stb,
  input  logic [8:0]               x_pac,
  input  logic [8:0]               y_pac,
  input  logic [N_GHOSTS-1:0][8:0] x_ghost,
  input  logic [N_GHOSTS-1:0][8:0] y_ghost,
  output logic [2:0]               state,
  output logic [SCORE_W-1:0]       score,
  output logic [1:0]               lives,
  output logic [3:0]               level,
  output logic                     frightened,
  output logic [N_GHOSTS-1:0]      ghost_eaten,
  output logic                     freeze,
  output logic                     pos_reset_stb
);

  localparam int FRM_RD  = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
  localparam int FRM_MAX = (FRM_RD > CLEAR_FRAMES) ? FRM_RD : CLEAR_FRAMES;
  localparam int FW      = $clog2(FRM_MAX + 1);
  localparam int TW      = $clog2(FRIGHT_FRAMES + 1);
  localparam int CW      = $clog2(CANDY_TOTAL + 2);
  localparam int ADD_W   = 12;
  localparam int SUM_W   = ((SCORE_W > ADD_W) ? SCORE_W : ADD_W) + 1;

  // Reset asserts asynchronously everywhere but releases on the clock.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  logic [N_GHOSTS-1:0] w_coll;

  for (genvar g = 0; g < N_GHOSTS; g++) begin : g_coll
    game_state_ctrl_ghost_collide #(.COLL_DIST(COLL_DIST)) u_coll (
      .i_clk     (vga_pix_clk),
      .i_rst_n   (w_rst_n),
      .i_x_pac   (x_pac),
      .i_y_pac   (y_pac),
      .i_x_ghost (x_ghost[g]),
      .i_y_ghost (y_ghost[g]),
      .o_hit     (w_coll[g])
    );
  end

  game_state_t         r_state, w_state_nx;
  logic [FW-1:0]       r_fcnt, w_fcnt_nx;
  logic [TW-1:0]       r_ftmr, w_ftmr_nx;
  logic [CW-1:0]       r_cnt, w_cnt_nx, w_cnt_inc;
  logic [1:0]          r_chain, w_chain_nx;
  logic [SCORE_W-1:0]  r_score, w_score_nx;
  logic [1:0]          r_lives, w_lives_nx;
  logic [3:0]          r_level, w_level_nx;
  logic                r_fright, w_fright_nx;
  logic [N_GHOSTS-1:0] r_geaten, w_geaten_nx;
  logic                r_freeze, r_prs;

  logic                w_in_play, w_candy, w_cookie, w_lethal, w_fdone, w_enter_ready;
  logic [N_GHOSTS-1:0] w_eat_req, w_eat_oh;
  logic [ADD_W-1:0]    w_add;
  logic [SUM_W-1:0]    w_sum;

  assign w_in_play = (r_state == PLAY);
  assign w_candy   = w_in_play & ate_candy_stb;
  assign w_cookie  = w_in_play & ate_power_cookie_stb;
  // A cookie arriving with a hit is applied first; the hit is re-evaluated next cycle.
  assign w_eat_req = (w_in_play && r_fright && !w_cookie) ? (w_coll & ~r_geaten) : '0;
  assign w_eat_oh  = w_eat_req & (~w_eat_req + N_GHOSTS'(1));
  assign w_lethal  = w_in_play && !r_fright && !w_cookie && (|w_coll);
  assign w_fdone   = frame_stb && (r_fcnt <= FW'(1));
  assign w_cnt_inc = r_cnt + CW'(w_candy) + CW'(w_cookie);

  always_comb begin
    w_add = '0;
    if (w_candy)    w_add = w_add + ADD_W'(CANDY_PTS);
    if (w_cookie)   w_add = w_add + ADD_W'(COOKIE_PTS);
    if (|w_eat_oh)  w_add = w_add + (ADD_W'(GHOST_PTS_BASE) << r_chain);
    w_sum      = SUM_W'(r_score) + SUM_W'(w_add);
    w_score_nx = (w_sum[SUM_W-1:SCORE_W] != '0) ? '1 : w_sum[SCORE_W-1:0];

    w_state_nx    = r_state;
    w_fcnt_nx     = (frame_stb && r_fcnt != '0) ? r_fcnt - FW'(1) : r_fcnt;
    w_cnt_nx      = w_cnt_inc;
    w_lives_nx    = r_lives;
    w_level_nx    = r_level;
    w_enter_ready = 1'b0;

    w_fright_nx = r_fright;
    w_ftmr_nx   = r_ftmr;
    w_geaten_nx = r_geaten | w_eat_oh;
    w_chain_nx  = r_chain;
    if (|w_eat_oh && r_chain != CHAIN_MAX) w_chain_nx = r_chain + 2'd1;

    if (w_cookie) begin
      w_fright_nx = 1'b1;
      w_ftmr_nx   = TW'(FRIGHT_FRAMES);
      w_geaten_nx = '0;
      w_chain_nx  = '0;
    end else if (r_fright && frame_stb) begin
      if (r_ftmr <= TW'(1)) begin
        w_fright_nx = 1'b0;
        w_ftmr_nx   = '0;
        w_geaten_nx = '0;
        w_chain_nx  = '0;
      end else begin
        w_ftmr_nx = r_ftmr - TW'(1);
      end
    end

    case (r_state)
      IDLE: if (start_btn) begin
        w_state_nx    = READY;
        w_fcnt_nx     = FW'(READY_FRAMES);
        w_enter_ready = 1'b1;
      end
      READY: if (w_fdone) w_state_nx = PLAY;
      // Clearing the level takes priority over a lethal hit in the same cycle.
      PLAY: if (w_cnt_inc >= CW'(CANDY_TOTAL)) begin
        w_state_nx = LEVEL_CLEAR;
        w_fcnt_nx  = FW'(CLEAR_FRAMES);
      end else if (w_lethal) begin
        w_state_nx = DYING;
        w_fcnt_nx  = FW'(DEATH_FRAMES);
      end
      DYING: if (w_fdone) begin
        w_lives_nx = (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
        if (r_lives <= 2'd1) begin
          w_state_nx = GAME_OVER;
        end else begin
          w_state_nx    = READY;
          w_fcnt_nx     = FW'(READY_FRAMES);
          w_enter_ready = 1'b1;
        end
      end
      LEVEL_CLEAR: if (w_fdone) begin
        w_state_nx    = READY;
        w_fcnt_nx     = FW'(READY_FRAMES);
        w_enter_ready = 1'b1;
        w_level_nx    = r_level + 4'd1;
        w_cnt_nx      = '0;
      end
      GAME_OVER: if (start_btn) begin
        w_state_nx = IDLE;
        w_score_nx = '0;
        w_lives_nx = 2'(LIVES_INIT);
        w_level_nx = '0;
        w_cnt_nx   = '0;
        w_fcnt_nx  = '0;
      end
      default: w_state_nx = IDLE;
    endcase

    if (w_in_play && w_state_nx != PLAY) begin
      w_fright_nx = 1'b0;
      w_ftmr_nx   = '0;
      w_geaten_nx = '0;
      w_chain_nx  = '0;
    end
  end

  always_ff @(posedge vga_pix_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= IDLE;
      r_fcnt   <= '0;
      r_ftmr   <= '0;
      r_cnt    <= '0;
      r_chain  <= '0;
      r_score  <= '0;
      r_lives  <= 2'(LIVES_INIT);
      r_level  <= '0;
      r_fright <= 1'b0;
      r_geaten <= '0;
      r_freeze <= 1'b1;
      r_prs    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_fcnt   <= w_fcnt_nx;
      r_ftmr   <= w_ftmr_nx;
      r_cnt    <= w_cnt_nx;
      r_chain  <= w_chain_nx;
      r_score  <= w_score_nx;
      r_lives  <= w_lives_nx;
      r_level  <= w_level_nx;
      r_fright <= w_fright_nx;
      r_geaten <= w_geaten_nx;
      r_freeze <= (w_state_nx != PLAY);
      r_prs    <= w_enter_ready;
    end
  end

  assign state         = r_state;
  assign score         = r_score;
  assign lives         = r_lives;
  assign level         = r_level;
  assign frightened    = r_fright;
  assign ghost_eaten   = r_geaten;
  assign freeze        = r_freeze;
  assign pos_reset_stb = r_prs;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: game flow, scoring, fright, collisions, reset.
module tb_game_state_ctrl;
  import game_state_ctrl_pkg::*;

  localparam int NG = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               frame_stb, start_btn, candy, cookie;
  logic [8:0]         x_pac, y_pac;
  logic [NG-1:0][8:0] x_ghost, y_ghost;
  logic [2:0]         state;
  logic [15:0]        score;
  logic [1:0]         lives;
  logic [3:0]         level;
  logic               frightened, freeze, pos_reset_stb;
  logic [NG-1:0]      ghost_eaten;

  int n_chk  = 0;
  int n_fail = 0;
  int n_prs  = 0;
  int p0;

  always #5 clk = ~clk;

  game_state_ctrl dut (
    .vga_pix_clk          (clk),
    .rst_n                (rst_n),
    .frame_stb            (frame_stb),
    .start_btn            (start_btn),
    .ate_candy_stb        (candy),
    .ate_power_cookie_stb (cookie),
    .x_pac                (x_pac),
    .y_pac                (y_pac),
    .x_ghost              (x_ghost),
    .y_ghost              (y_ghost),
    .state                (state),
    .score                (score),
    .lives                (lives),
    .level                (level),
    .frightened           (frightened),
    .ghost_eaten          (ghost_eaten),
    .freeze               (freeze),
    .pos_reset_stb        (pos_reset_stb)
  );

  always @(negedge clk) if (pos_reset_stb) n_prs++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_stb = 1'b1; tick();
      frame_stb = 1'b0; tick();
    end
  endtask

  task automatic pulse_candy();
    candy = 1'b1; tick(); candy = 1'b0;
  endtask

  task automatic pulse_cookie();
    cookie = 1'b1; tick(); cookie = 1'b0;
  endtask

  task automatic ghosts_far();
    for (int i = 0; i < NG; i++) begin
      x_ghost[i] = 9'd200;
      y_ghost[i] = 9'd200;
    end
  endtask

  task automatic ghosts_on_pac();
    for (int i = 0; i < NG; i++) begin
      x_ghost[i] = x_pac;
      y_ghost[i] = y_pac;
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_state"},  32'(state), 32'(IDLE));
    chk({pfx, "_score"},  32'(score), 0);
    chk({pfx, "_lives"},  32'(lives), 3);
    chk({pfx, "_level"},  32'(level), 0);
    chk({pfx, "_fright"}, 32'(frightened), 0);
    chk({pfx, "_geaten"}, 32'(ghost_eaten), 0);
    chk({pfx, "_freeze"}, 32'(freeze), 1);
    chk({pfx, "_prs"},    32'(pos_reset_stb), 0);
  endtask

  // Lethal hit with ghost 0 at dx=3, then wait out the death animation.
  task automatic die(input string tag);
    x_ghost[0] = x_pac + 9'd3;
    y_ghost[0] = y_pac;
    tick();
    chk({tag, "_still_play"}, 32'(state), 32'(PLAY));
    tick();
    chk({tag, "_dying"}, 32'(state), 32'(DYING));
    chk({tag, "_freeze"}, 32'(freeze), 1);
    ghosts_far();
    frames(89);
    chk({tag, "_dying89"}, 32'(state), 32'(DYING));
    frames(1);
  endtask

  initial begin
    rst_n = 1'b0; frame_stb = 1'b0; start_btn = 1'b0; candy = 1'b0; cookie = 1'b0;
    x_pac = 9'd10; y_pac = 9'd10;
    ghosts_far();
    tick(3);
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick(3);

    // Start: READY then PLAY after 120 frames
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    chk("ready", 32'(state), 32'(READY));
    chk("ready_prs", 32'(pos_reset_stb), 1);
    frames(119);
    chk("ready119", 32'(state), 32'(READY));
    frames(1);
    chk("play", 32'(state), 32'(PLAY));
    chk("play_freeze", 32'(freeze), 0);
    chk("prs_once", n_prs, 1);

    // Candy and cookie scoring, fright timeout
    repeat (3) pulse_candy();
    chk("candy30", 32'(score), 30);
    pulse_cookie();
    chk("score80", 32'(score), 80);
    chk("fright_on", 32'(frightened), 1);
    frames(359);
    chk("fright359", 32'(frightened), 1);
    frames(1);
    chk("fright_off", 32'(frightened), 0);

    // Four simultaneous eats served one per cycle
    pulse_cookie();
    chk("score130", 32'(score), 130);
    ghosts_on_pac();
    tick();
    chk("eat0", 32'(ghost_eaten), 32'h0);
    tick(); chk("eat1", 32'(ghost_eaten), 32'h1);
    tick(); chk("eat2", 32'(ghost_eaten), 32'h3);
    tick(); chk("eat3", 32'(ghost_eaten), 32'h7);
    tick(); chk("eat4", 32'(ghost_eaten), 32'hF);
    chk("score3130", 32'(score), 3130);
    tick(3);
    chk("recollide", 32'(score), 3130);
    chk("recollide_st", 32'(state), 32'(PLAY));
    ghosts_far();
    tick(2);
    frames(360);
    chk("fright_off2", 32'(frightened), 0);
    chk("geaten_clr", 32'(ghost_eaten), 0);

    // dx=4 is outside the collision box
    x_ghost[0] = x_pac + 9'd4;
    y_ghost[0] = y_pac;
    tick(3);
    chk("dx4_safe", 32'(state), 32'(PLAY));
    ghosts_far();
    tick();

    // Deaths down to GAME_OVER
    p0 = n_prs;
    die("d1");
    chk("d1_ready", 32'(state), 32'(READY));
    chk("d1_lives", 32'(lives), 2);
    chk("d1_prs", n_prs - p0, 1);
    chk("d1_score", 32'(score), 3130);
    frames(120);
    die("d2");
    chk("d2_lives", 32'(lives), 1);
    frames(120);
    die("d3");
    chk("gameover", 32'(state), 32'(GAME_OVER));
    chk("go_lives", 32'(lives), 0);
    pulse_candy();
    chk("go_candy_ignored", 32'(score), 3130);
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    chk("idle", 32'(state), 32'(IDLE));
    chk("idle_lives", 32'(lives), 3);
    chk("idle_score", 32'(score), 0);

    // New game: drive score into saturation with chained eats
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    frames(120);
    chk("play2", 32'(state), 32'(PLAY));
    for (int k = 0; k < 22; k++) begin
      pulse_cookie();
      if (k == 0) ghosts_on_pac();
      tick(6);
      if (k == 20) chk("score64050", 32'(score), 64050);
    end
    chk("score_sat", 32'(score), 65535);
    ghosts_far();
    tick(2);
    repeat (221) pulse_candy();
    frames(360);
    chk("pre_final_fright", 32'(frightened), 0);
    chk("pre_final_st", 32'(state), 32'(PLAY));

    // Final candy coincides with a lethal hit
    x_ghost[0] = x_pac + 9'd3;
    y_ghost[0] = y_pac;
    tick();
    pulse_candy();
    chk("lvl_clear", 32'(state), 32'(LEVEL_CLEAR));
    chk("lvl_lives", 32'(lives), 3);
    chk("lvl_score", 32'(score), 65535);
    ghosts_far();
    frames(119);
    chk("clear119", 32'(state), 32'(LEVEL_CLEAR));
    p0 = n_prs;
    frames(1);
    chk("lvl_ready", 32'(state), 32'(READY));
    chk("level1", 32'(level), 1);
    chk("lvl_prs", n_prs - p0, 1);

    // Asynchronous reset during fright
    frames(120);
    pulse_cookie();
    chk("fright_before_rst", 32'(frightened), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
